// File: rtl/knn_frame_loader.sv
// Frame loader for the dist_sort nearest-vector sorter: packs a 16-bit word stream
// into query + 8 search vectors, fires the sorter, returns the two closest addresses.
// Optional WAIT watchdog is enabled with `define KNN_LOADER_TIMEOUT_EN.
//
// state | meaning
// LOAD  | accepting stream words into the vector registers
// FIRE  | one-cycle sort request to dist_sort
// WAIT  | waiting for the sorter result (or watchdog expiry)
// RESP  | presenting the result to the host until accepted
module knn_frame_loader #(
    parameter int WORD_W         = 16,
    parameter int FRAME_WORDS    = 36,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [63:0]       ds_query,
    output logic [63:0]       ds_search_0,
    output logic [63:0]       ds_search_1,
    output logic [63:0]       ds_search_2,
    output logic [63:0]       ds_search_3,
    output logic [63:0]       ds_search_4,
    output logic [63:0]       ds_search_5,
    output logic [63:0]       ds_search_6,
    output logic [63:0]       ds_search_7,
    output logic              ds_in_valid,
    input  logic [2:0]        ds_addr_1st,
    input  logic [2:0]        ds_addr_2nd,
    input  logic              ds_out_valid,
    output logic [2:0]        res_addr_1st,
    output logic [2:0]        res_addr_2nd,
    output logic              res_timeout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              frame_err,
    output logic              busy
);

    localparam int VEC_W    = 64;
    localparam int WPV      = VEC_W / WORD_W;
    localparam int NVEC     = FRAME_WORDS / WPV;
    localparam int LAST_IDX = FRAME_WORDS - 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [5:0]       word_cnt;
    logic [VEC_W-1:0] vec_q [NVEC];
    logic             accept;
    logic             cnt_last;
    logic             wd_expire;
    logic [3:0]       vec_idx;
    logic [1:0]       lane;

    assign accept   = s_valid & s_ready;
    assign cnt_last = (word_cnt == 6'(LAST_IDX));
    assign vec_idx  = word_cnt[5:2];
    assign lane     = word_cnt[1:0];
    assign busy     = (state != LOAD);

    assign ds_query    = vec_q[0];
    assign ds_search_0 = vec_q[1];
    assign ds_search_1 = vec_q[2];
    assign ds_search_2 = vec_q[3];
    assign ds_search_3 = vec_q[4];
    assign ds_search_4 = vec_q[5];
    assign ds_search_5 = vec_q[6];
    assign ds_search_6 = vec_q[7];
    assign ds_search_7 = vec_q[8];

`ifdef KNN_LOADER_TIMEOUT_EN
    localparam logic [4:0] WD_LOAD = 5'(TIMEOUT_CYCLES - 1);

    logic [4:0] wd_cnt;
    logic       timeout_q;

    assign wd_expire   = (wd_cnt == 5'd0);
    assign res_timeout = timeout_q;

    // Down-counter loaded in FIRE; reaching zero in WAIT marks the last allowed cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == FIRE)
                wd_cnt <= WD_LOAD;
            else if (state == WAIT && wd_cnt != 5'd0)
                wd_cnt <= wd_cnt - 5'd1;
            if (state == WAIT) begin
                if (ds_out_valid)
                    timeout_q <= 1'b0;
                else if (wd_expire)
                    timeout_q <= 1'b1;
            end
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign res_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NVEC; v++)
                vec_q[v] <= '0;
        end else if (accept) begin
            vec_q[vec_idx][lane*WORD_W +: WORD_W] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOAD;
            word_cnt     <= '0;
            frame_err    <= 1'b0;
            res_addr_1st <= '0;
            res_addr_2nd <= '0;
        end else begin
            state     <= state_nxt;
            // s_last must coincide exactly with the final word of the frame
            frame_err <= accept && (s_last != cnt_last);
            if (accept)
                word_cnt <= (s_last || cnt_last) ? 6'd0 : word_cnt + 6'd1;
            if (state == WAIT) begin
                if (ds_out_valid) begin
                    res_addr_1st <= ds_addr_1st;
                    res_addr_2nd <= ds_addr_2nd;
                end else if (wd_expire) begin
                    res_addr_1st <= '0;
                    res_addr_2nd <= '0;
                end
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        s_ready     = 1'b0;
        ds_in_valid = 1'b0;
        res_valid   = 1'b0;
        case (state)
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid && s_last && cnt_last)
                    state_nxt = FIRE;
            end
            FIRE: begin
                ds_in_valid = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (ds_out_valid || wd_expire)
                    state_nxt = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

endmodule

// File: tb/tb_knn_frame_loader.sv
// Scoreboard bench for knn_frame_loader with a behavioural 3-cycle dist_sort stand-in.
// Honours KNN_LOADER_TIMEOUT_EN for the stub-sorter scenario.
module tb_knn_frame_loader;

    typedef logic [9*64-1:0] frame_t;
    typedef struct packed {
        logic [2:0] a1;
        logic [2:0] a2;
        logic       to;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid, s_last, s_ready;
    logic [63:0] ds_query;
    logic [63:0] ds_search [8];
    logic        ds_in_valid;
    logic [2:0]  ds_addr_1st, ds_addr_2nd;
    logic        ds_out_valid;
    logic [2:0]  res_addr_1st, res_addr_2nd;
    logic        res_timeout, res_valid, res_ready;
    logic        frame_err, busy;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     ncyc    = 0;
    int     last_acc = 0;
    int     exp_lat  = 5;
    logic   sorter_en;
    logic   res_prev;
    res_t   held;
    res_t   exp_r;
    frame_t mon_f;
    frame_t fa, fb, fc;
    frame_t frame_q [$];
    res_t   res_q [$];

    logic [2:0] pipe;
    logic [2:0] srt_a1, srt_a2;

    always #5 clk = ~clk;

    knn_frame_loader dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .ds_query(ds_query),
        .ds_search_0(ds_search[0]), .ds_search_1(ds_search[1]),
        .ds_search_2(ds_search[2]), .ds_search_3(ds_search[3]),
        .ds_search_4(ds_search[4]), .ds_search_5(ds_search[5]),
        .ds_search_6(ds_search[6]), .ds_search_7(ds_search[7]),
        .ds_in_valid(ds_in_valid),
        .ds_addr_1st(ds_addr_1st), .ds_addr_2nd(ds_addr_2nd), .ds_out_valid(ds_out_valid),
        .res_addr_1st(res_addr_1st), .res_addr_2nd(res_addr_2nd),
        .res_timeout(res_timeout), .res_valid(res_valid), .res_ready(res_ready),
        .frame_err(frame_err), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sad(input logic [63:0] a, input logic [63:0] b);
        int s = 0;
        for (int j = 0; j < 8; j++) begin
            int x = int'(a[j*8 +: 8]);
            int y = int'(b[j*8 +: 8]);
            s += (x > y) ? x - y : y - x;
        end
        return s;
    endfunction

    // Closest two by byte-wise absolute difference; ties resolve to the lower index.
    function automatic logic [5:0] tb_sort();
        int b1 = -1, b2 = -1, d1 = 0, d2 = 0;
        for (int k = 0; k < 8; k++) begin
            int d = sad(ds_query, ds_search[k]);
            if (b1 < 0 || d < d1) begin
                b2 = b1; d2 = d1; b1 = k; d1 = d;
            end else if (b2 < 0 || d < d2) begin
                b2 = k; d2 = d;
            end
        end
        return {3'(b1), 3'(b2)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe   <= '0;
            srt_a1 <= '0;
            srt_a2 <= '0;
        end else begin
            pipe <= {pipe[1:0], ds_in_valid};
            if (ds_in_valid)
                {srt_a1, srt_a2} <= tb_sort();
        end
    end

    assign ds_out_valid = pipe[2] & sorter_en;
    assign ds_addr_1st  = sorter_en ? srt_a1 : 3'd7;
    assign ds_addr_2nd  = sorter_en ? srt_a2 : 3'd6;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            res_prev = 1'b0;
        end else begin
            if (s_valid && s_ready && s_last)
                last_acc = ncyc;
            if (ds_in_valid) begin
                check("fire_latency", 64'(ncyc), 64'(last_acc + 1));
                if (frame_q.size() == 0) begin
                    check("unexpected_fire", 1, 0);
                end else begin
                    mon_f = frame_q.pop_front();
                    check("ds_query", ds_query, mon_f[63:0]);
                    for (int k = 0; k < 8; k++)
                        check("ds_search", ds_search[k], mon_f[(k+1)*64 +: 64]);
                end
            end
            if (res_valid && !res_prev)
                check("res_latency", 64'(ncyc), 64'(last_acc + exp_lat));
            if (res_valid)
                check("s_ready_in_resp", s_ready, 0);
            if (res_valid && res_prev)
                check("res_stable", {res_addr_1st, res_addr_2nd, res_timeout}, held);
            if (res_valid && res_ready) begin
                if (res_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_r = res_q.pop_front();
                    check("res_addr_1st", res_addr_1st, exp_r.a1);
                    check("res_addr_2nd", res_addr_2nd, exp_r.a2);
                    check("res_timeout", res_timeout, exp_r.to);
                end
            end
            res_prev = res_valid;
            held     = {res_addr_1st, res_addr_2nd, res_timeout};
        end
    end

    task automatic send_words(input frame_t f, input int nwords, input int last_at);
        int waited;
        for (int i = 0; i < nwords; i++) begin
            s_data  = f[(i/4)*64 + (i%4)*16 +: 16];
            s_valid = 1'b1;
            s_last  = (i == last_at);
            waited  = 0;
            @(negedge clk);
            while (!s_ready && waited < 300) begin
                @(negedge clk);
                waited++;
            end
            if (!s_ready) begin
                check("s_ready_wait", 0, 1);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame(input frame_t f, input logic [2:0] a1, input logic [2:0] a2,
                             input logic to);
        frame_q.push_back(f);
        res_q.push_back('{a1: a1, a2: a2, to: to});
        send_words(f, 36, 35);
    endtask

    task automatic wait_idle();
        int waited = 0;
        @(negedge clk);
        while ((busy || res_q.size() != 0) && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("idle_wait", {busy, 1'b0} | 2'(res_q.size() != 0), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"}, s_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_ds_in_valid"}, ds_in_valid, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_res_addr"}, {res_addr_1st, res_addr_2nd, res_timeout}, 0);
        check({tag, "_ds_query"}, ds_query, 0);
        check({tag, "_ds_search_7"}, ds_search[7], 0);
    endtask

    initial begin
        int bad;
        rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        res_ready = 1'b1; sorter_en = 1'b1;

        fa = '0;
        fb = '0;
        fc = '0;
        fc[63:0] = {16{4'h1}};
        for (int k = 0; k < 8; k++) begin
            fa[(k+1)*64 +: 64] = {16{4'(k)}};
            fb[(k+1)*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
            fc[(k+1)*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        fc[6*64 +: 64] = 64'h1111_1111_1111_1112;
        fc[3*64 +: 64] = 64'h1111_1111_1111_1113;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("in_reset");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("after_reset");
        @(posedge clk); #1;

        run_frame(fa, 3'd0, 3'd1, 1'b0);
        run_frame(fb, 3'd0, 3'd1, 1'b0);
        run_frame(fc, 3'd5, 3'd2, 1'b0);

        // early s_last on word 10
        send_words(fc, 11, 10);
        @(negedge clk);
        check("err_early_pulse", frame_err, 1);
        check("err_early_s_ready", s_ready, 1);
        check("err_early_busy", busy, 0);
        @(negedge clk);
        check("err_early_one_cycle", frame_err, 0);
        @(posedge clk); #1;
        run_frame(fa, 3'd0, 3'd1, 1'b0);

        // word 35 without s_last
        send_words(fb, 36, 99);
        @(negedge clk);
        check("err_nolast_pulse", frame_err, 1);
        check("err_nolast_busy", busy, 0);
        @(posedge clk); #1;
        run_frame(fc, 3'd5, 3'd2, 1'b0);

        // host stalls the result for 20 cycles
        wait_idle();
        @(posedge clk); #1 res_ready = 1'b0;
        run_frame(fb, 3'd0, 3'd1, 1'b0);
        bad = 1;
        for (int w = 0; w < 50 && bad != 0; w++) begin
            @(negedge clk);
            if (res_valid) bad = 0;
        end
        check("stall_res_seen", bad, 0);
        repeat (20) @(negedge clk);
        check("stall_res_held", res_valid, 1);
        check("stall_busy", busy, 1);
        @(posedge clk); #1 res_ready = 1'b1;

        // reset in the middle of a frame
        wait_idle();
        @(posedge clk); #1;
        send_words(fa, 20, 99);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_reset");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_frame(fc, 3'd5, 3'd2, 1'b0);

        // sorter that never answers
        wait_idle();
        @(posedge clk); #1 sorter_en = 1'b0;
`ifdef KNN_LOADER_TIMEOUT_EN
        exp_lat = 17;
        run_frame(fa, 3'd0, 3'd0, 1'b1);
        wait_idle();
        @(posedge clk); #1 exp_lat = 5; sorter_en = 1'b1;
`else
        frame_q.push_back(fa);
        send_words(fa, 36, 35);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b1 || res_valid !== 1'b0) bad = 1;
        end
        check("stub_hold", bad, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; sorter_en = 1'b1;
        @(posedge clk); #1;
`endif
        run_frame(fa, 3'd0, 3'd1, 1'b0);
        wait_idle();
        check("frame_q_empty", 64'(frame_q.size()), 0);
        check("res_q_empty", 64'(res_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
